// File: rtl/sram_arbiter.sv
// sram_arbiter: CPU/DMA arbiter for one single-port SRAM with lock and read return.
// Define SRAM_ARB_FAIRNESS_EN to enable the DMA anti-starvation counter.
module sram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_di,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_do,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_di,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_do,
  output logic [ADDR_W-1:0] sram_ADDR,
  output logic [DATA_W-1:0] sram_DI,
  output logic              sram_EN,
  output logic              sram_WE,
  input  logic [DATA_W-1:0] sram_DO
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("sram_arbiter: STARVE_LIMIT must be 1..15");
  end

  logic [1:0] r_own;
  logic       r_lock;
  logic       r_rd_cpu;
  logic       r_rd_dma;

  logic w_cpu_lk;
  logic w_dma_lk;
  logic w_fair;
  logic w_cpu_gnt;
  logic w_dma_gnt;
  logic w_cpu_rv;
  logic w_dma_rv;

  // A lock only counts if the previous owner still requests.
  assign w_cpu_lk = r_lock & (r_own == OWN_CPU) & cpu_req;
  assign w_dma_lk = r_lock & (r_own == OWN_DMA) & dma_req;

`ifdef SRAM_ARB_FAIRNESS_EN
  logic [3:0] r_starve;

  assign w_fair = (r_starve == 4'(STARVE_LIMIT)) & dma_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= 4'd0;
    end else if (!dma_req || w_dma_gnt) begin
      r_starve <= 4'd0;
    end else if (w_cpu_gnt && r_starve != 4'(STARVE_LIMIT)) begin
      r_starve <= r_starve + 4'd1;
    end
  end
`else
  assign w_fair = 1'b0;
`endif

  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    priority case (1'b1)
      reset:    ;
      w_cpu_lk: w_cpu_gnt = 1'b1;
      w_dma_lk: w_dma_gnt = 1'b1;
      w_fair:   w_dma_gnt = 1'b1;
      cpu_req:  w_cpu_gnt = 1'b1;
      dma_req:  w_dma_gnt = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_own    <= OWN_NONE;
      r_lock   <= 1'b0;
      r_rd_cpu <= 1'b0;
      r_rd_dma <= 1'b0;
    end else begin
      r_rd_cpu <= w_cpu_gnt & ~cpu_we;
      r_rd_dma <= w_dma_gnt & ~dma_we;
      if (w_cpu_gnt) begin
        r_own  <= OWN_CPU;
        r_lock <= cpu_lock;
      end else if (w_dma_gnt) begin
        r_own  <= OWN_DMA;
        r_lock <= dma_lock;
      end else begin
        r_own  <= OWN_NONE;
        r_lock <= 1'b0;
      end
    end
  end

  assign cpu_gnt = w_cpu_gnt;
  assign dma_gnt = w_dma_gnt;

  assign sram_EN   = w_cpu_gnt | w_dma_gnt;
  assign sram_WE   = w_cpu_gnt ? cpu_we
                   : w_dma_gnt ? dma_we : 1'b0;
  assign sram_ADDR = w_cpu_gnt ? cpu_addr
                   : w_dma_gnt ? dma_addr : '0;
  assign sram_DI   = w_cpu_gnt ? cpu_di
                   : w_dma_gnt ? dma_di : '0;

  // A reset landing on the return cycle drops the pending read.
  assign w_cpu_rv   = r_rd_cpu & ~reset;
  assign w_dma_rv   = r_rd_dma & ~reset;
  assign cpu_rvalid = w_cpu_rv;
  assign dma_rvalid = w_dma_rv;
  assign cpu_do     = w_cpu_rv ? sram_DO : '0;
  assign dma_do     = w_dma_rv ? sram_DO : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and random stimulus against a behavioural model
// of the arbiter and a bench-side SRAM.
module tb_sram_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int LIM = 4;
`ifdef SRAM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_lock;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_di;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_do;
  logic          dma_req, dma_we, dma_lock;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_di;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_do;
  logic [AW-1:0] sram_ADDR;
  logic [DW-1:0] sram_DI;
  logic          sram_EN, sram_WE;
  logic [DW-1:0] sram_DO;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
    .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_do(cpu_do),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
    .dma_addr(dma_addr), .dma_di(dma_di), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_do(dma_do),
    .sram_ADDR(sram_ADDR), .sram_DI(sram_DI), .sram_EN(sram_EN),
    .sram_WE(sram_WE), .sram_DO(sram_DO)
  );

  // Bench SRAM: one-cycle read latency.
  logic          mem_clr;
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      sram_DO <= '0;
    end else if (sram_EN) begin
      if (sram_WE) mem[sram_ADDR[7:0]] <= sram_DI;
      else sram_DO <= mem[sram_ADDR[7:0]];
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  int            m_own;
  bit            m_lock;
  int            m_wait;
  bit            m_rc, m_rd;
  logic [DW-1:0] m_cdata, m_ddata;
  logic [DW-1:0] ref_mem [256];
  int            pat;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit            ec, ed, ewe, rvc, rvd;
    logic [AW-1:0] ea;
    logic [DW-1:0] edi;
    @(negedge clk);
    ec = 1'b0;
    ed = 1'b0;
    if (!reset) begin
      if (m_lock && m_own == 1 && cpu_req) ec = 1'b1;
      else if (m_lock && m_own == 2 && dma_req) ed = 1'b1;
      else if (FAIR && m_wait >= LIM && dma_req) ed = 1'b1;
      else if (cpu_req) ec = 1'b1;
      else if (dma_req) ed = 1'b1;
    end
    ea  = ec ? cpu_addr : (ed ? dma_addr : '0);
    edi = ec ? cpu_di : (ed ? dma_di : '0);
    ewe = ec ? cpu_we : (ed ? dma_we : 1'b0);
    rvc = m_rc && !reset;
    rvd = m_rd && !reset;
    chk("cpu_gnt", 64'(cpu_gnt), 64'(ec));
    chk("dma_gnt", 64'(dma_gnt), 64'(ed));
    chk("sram_EN", 64'(sram_EN), 64'(ec | ed));
    chk("sram_WE", 64'(sram_WE), 64'(ewe));
    chk("sram_ADDR", 64'(sram_ADDR), 64'(ea));
    chk("sram_DI", 64'(sram_DI), 64'(edi));
    chk("cpu_rvalid", 64'(cpu_rvalid), 64'(rvc));
    chk("cpu_do", 64'(cpu_do), 64'(rvc ? m_cdata : '0));
    chk("dma_rvalid", 64'(dma_rvalid), 64'(rvd));
    chk("dma_do", 64'(dma_do), 64'(rvd ? m_ddata : '0));
    if (pat >= 0) chk("grant_seq", 64'({dma_gnt, cpu_gnt}), 64'(pat));
    if (reset) begin
      m_own = 0; m_lock = 1'b0; m_wait = 0; m_rc = 1'b0; m_rd = 1'b0;
    end else begin
      m_rc = ec && !cpu_we;
      m_rd = ed && !dma_we;
      if (m_rc) m_cdata = ref_mem[cpu_addr[7:0]];
      if (m_rd) m_ddata = ref_mem[dma_addr[7:0]];
      if (ec && cpu_we) ref_mem[cpu_addr[7:0]] = cpu_di;
      if (ed && dma_we) ref_mem[dma_addr[7:0]] = dma_di;
      m_own  = ec ? 1 : (ed ? 2 : 0);
      m_lock = ec ? cpu_lock : (ed ? dma_lock : 1'b0);
      if (!dma_req || ed) m_wait = 0;
      else if (ec && m_wait < LIM) m_wait++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = '0; cpu_di = '0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_di = '0;
  endtask

  initial begin
    pat = -1;
    m_own = 0; m_lock = 0; m_wait = 0; m_rc = 0; m_rd = 0;
    m_cdata = '0; m_ddata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    idle_inputs();
    reset = 1'b1;
    mem_clr = 1'b1;
    @(posedge clk);
    #1;
    mem_clr = 1'b0;

    // Reset: outputs quiet, even with a request present
    step();
    cpu_req = 1; dma_req = 1;
    pat = 0;
    step();
    pat = -1;
    idle_inputs();
    reset = 1'b0;
    repeat (3) step();

    // CPU write then read of 0x0005
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0005; cpu_di = 32'hDEADBEEF;
    step();
    cpu_we = 0; cpu_di = '0;
    step();
    idle_inputs();
    step();

    // Continuous requests from both ports
    for (int i = 0; i < 10; i++) begin
      cpu_req = 1; dma_req = 1;
      cpu_addr = 16'($urandom_range(0, 15));
      dma_addr = 16'($urandom_range(0, 15));
      pat = (FAIR && (i % 5 == 4)) ? 2 : 1;
      step();
    end
    pat = -1;
    idle_inputs();
    step();

    // DMA locked read then write while CPU waits
    dma_req = 1; dma_lock = 1; dma_addr = 16'h0010;
    pat = 2;
    step();
    cpu_req = 1; cpu_addr = 16'h0001;
    dma_lock = 0; dma_we = 1; dma_addr = 16'h0020; dma_di = 32'hA5A5_0020;
    step();
    dma_req = 0; dma_we = 0;
    pat = 1;
    step();
    pat = -1;
    idle_inputs();
    step();

    // CPU write then DMA read of the same word
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0003; cpu_di = 32'h12345678;
    step();
    idle_inputs();
    dma_req = 1; dma_addr = 16'h0003;
    step();
    idle_inputs();
    step();

    // Reset right after a granted CPU read
    cpu_req = 1; dma_req = 1; cpu_addr = 16'h0005;
    repeat (3) step();
    reset = 1'b1;
    pat = 0;
    step();
    reset = 1'b0;
    idle_inputs();
    step();
    for (int i = 0; i < 5; i++) begin
      cpu_req = 1; dma_req = 1;
      pat = (FAIR && i == 4) ? 2 : 1;
      step();
    end
    pat = -1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 63) == 0);
      cpu_req  = ($urandom_range(0, 3) != 0);
      cpu_we   = $urandom_range(0, 1) == 1;
      cpu_lock = ($urandom_range(0, 3) == 0);
      cpu_addr = 16'($urandom_range(0, 15));
      cpu_di   = $urandom;
      dma_req  = ($urandom_range(0, 2) != 0);
      dma_we   = $urandom_range(0, 1) == 1;
      dma_lock = ($urandom_range(0, 3) == 0);
      dma_addr = 16'($urandom_range(0, 15));
      dma_di   = $urandom;
      step();
    end
    reset = 1'b0;
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
